// File: rtl/simple_bus_mem_responder.sv
// Memory-side simple_bus responder: req/gnt grant, start/rdy transfers, 2^AW x DW register memory.
// Latency: gnt 1 cycle after req; rdy WAIT_CYCLES+1 cycles after accepted start or previous burst beat.
// Backpressure: none; starts arriving while busy or ungranted are dropped, and req low aborts a transfer.
//
// Ports:
//   clk, rst             clock (rising edge) and asynchronous active-high reset
//   req / gnt            bus request from the initiator, registered grant back to it
//   start, addr, mode,   one-cycle transfer strobe with its address, mode (00 nop,
//   wdata                01 read, 10 write, 11 burst read) and write data
//   rdy / rdata          one-cycle completion/beat strobe and its read data
//   err                  only when SB_MEM_PROT_ERR_EN is defined: nop completion or busy start
module simple_bus_mem_responder #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int BURST_LEN   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    output logic          gnt,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] wdata,
    input  logic          start,
    output logic [DW-1:0] rdata,
    output logic          rdy
`ifdef SB_MEM_PROT_ERR_EN
    ,
    output logic          err
`endif
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    localparam logic [3:0]    WAIT_LD   = 4'(WAIT_CYCLES);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        ACCESS  = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    mode_q, mode_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    wait_q, wait_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          gnt_q, gnt_d;
    logic          rdy_q, rdy_d;
    logic [DW-1:0] rdata_q, rdata_d;
`ifdef SB_MEM_PROT_ERR_EN
    logic          err_q, err_d;
`endif

    logic [DW-1:0] mem_q [2**AW];
    logic          mem_we;
    logic          resp_read;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = GRANTED;
                end
            end

            GRANTED: begin
                // A start coinciding with req falling is dropped: release wins.
                if (!req) begin
                    state_d = IDLE;
                end else if (start) begin
                    addr_d  = addr;
                    mode_d  = mode;
                    wdata_d = wdata;
                    beat_d  = '0;
                    wait_d  = WAIT_LD;
                    // With no wait cycles the very next cycle is already the response.
                    state_d = (WAIT_LD == 4'd0) ? RESP : ACCESS;
                end
            end

            ACCESS: begin
                // ACCESS spans WAIT_CYCLES cycles, so the last one is wait_q == 1.
                if (!req) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                    if (wait_q <= 4'd1) begin
                        state_d = RESP;
                    end
                end
            end

            RESP: begin
                // The response cycle is already visible on rdy, so a write
                // commits even if req drops in this same cycle.
                mem_we = (mode_q == MODE_WRITE);
                if (!req) begin
                    state_d = IDLE;
                end else if (mode_q == MODE_BURST && beat_q != LAST_BEAT) begin
                    addr_d  = addr_q + AW'(1);
                    beat_d  = beat_q + BW'(1);
                    wait_d  = WAIT_LD;
                    state_d = (WAIT_LD == 4'd0) ? RESP : ACCESS;
                end else begin
                    state_d = GRANTED;
                end
            end

            default: state_d = IDLE;
        endcase

        gnt_d = (state_d != IDLE);

        // Outputs are registered, so they are computed from the next-cycle
        // state and the address of the beat about to be presented.
        resp_read = (state_d == RESP) && (mode_d == MODE_READ || mode_d == MODE_BURST);
        rdata_d   = resp_read ? mem_q[addr_d] : '0;

`ifdef SB_MEM_PROT_ERR_EN
        rdy_d = (state_d == RESP) && (mode_d != 2'b00);
        err_d = ((state_d == RESP) && (mode_d == 2'b00))
              || (start && (state_q == ACCESS || state_q == RESP));
`else
        rdy_d = (state_d == RESP);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mode_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            beat_q  <= '0;
            gnt_q   <= 1'b0;
            rdy_q   <= 1'b0;
            rdata_q <= '0;
`ifdef SB_MEM_PROT_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            gnt_q   <= gnt_d;
            rdy_q   <= rdy_d;
            rdata_q <= rdata_d;
`ifdef SB_MEM_PROT_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign gnt   = gnt_q;
    assign rdy   = rdy_q;
    assign rdata = rdata_q;
`ifdef SB_MEM_PROT_ERR_EN
    assign err   = err_q;
`endif

endmodule

// File: tb/tb_simple_bus_mem_responder.sv
// Directed bench for simple_bus_mem_responder: default instance (WAIT_CYCLES=2)
// plus a WAIT_CYCLES=0 instance for back-to-back timing.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
module tb_simple_bus_mem_responder;

    localparam logic [1:0] M_NOP   = 2'b00;
    localparam logic [1:0] M_READ  = 2'b01;
    localparam logic [1:0] M_WRITE = 2'b10;
    localparam logic [1:0] M_BURST = 2'b11;

    logic       clk;
    logic       rst;

    logic       req, start, gnt, rdy;
    logic [7:0] addr, wdata, rdata;
    logic [1:0] mode;

    logic       req0, start0, gnt0, rdy0;
    logic [7:0] addr0, wdata0, rdata0;
    logic [1:0] mode0;

`ifdef SB_MEM_PROT_ERR_EN
    logic       err, err0;
`endif

    int passed = 0;
    int total  = 0;

    simple_bus_mem_responder u_dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .gnt   (gnt),
        .addr  (addr),
        .mode  (mode),
        .wdata (wdata),
        .start (start),
        .rdata (rdata),
        .rdy   (rdy)
`ifdef SB_MEM_PROT_ERR_EN
        ,
        .err   (err)
`endif
    );

    simple_bus_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .rst   (rst),
        .req   (req0),
        .gnt   (gnt0),
        .addr  (addr0),
        .mode  (mode0),
        .wdata (wdata0),
        .start (start0),
        .rdata (rdata0),
        .rdy   (rdy0)
`ifdef SB_MEM_PROT_ERR_EN
        ,
        .err   (err0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one transfer on the default instance from a GRANTED cycle; returns
    // cycles from start to rdy (-1 on timeout) and rdata at rdy. Ends in GRANTED.
    task automatic xfer(input logic [1:0] m, input logic [7:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd);
        lat   = -1;
        rd    = '0;
        mode  = m;
        addr  = a;
        wdata = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (rdy) begin
                lat = n;
                rd  = rdata;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic xfer0(input logic [1:0] m, input logic [7:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] rd);
        lat    = -1;
        rd     = '0;
        mode0  = m;
        addr0  = a;
        wdata0 = d;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (rdy0) begin
                lat = n;
                rd  = rdata0;
                break;
            end
            tick();
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         nr, rc, ne, ec;
        logic [7:0] rd;
        int         bt [4];
        logic [7:0] bd [4];

        rst = 1'b1;
        req = 1'b0;  start = 1'b0;  addr = '0;  mode = '0;  wdata = '0;
        req0 = 1'b0; start0 = 1'b0; addr0 = '0; mode0 = '0; wdata0 = '0;
        repeat (3) tick();

        // Reset values
        check("rst_gnt", gnt, 0);
        check("rst_rdy", rdy, 0);
        check("rst_rdata", rdata, 0);
`ifdef SB_MEM_PROT_ERR_EN
        check("rst_err", err, 0);
`endif
        rst = 1'b0;
        tick();

        // Grant latency: req at cycle 0 -> gnt at cycle 1; req low -> gnt low next cycle
        req = 1'b1;
        check("gnt_c0", gnt, 0);
        tick();
        check("gnt_c1", gnt, 1);
        req = 1'b0;
        tick();
        check("gnt_drop", gnt, 0);
        req = 1'b1;
        tick();

        // Write 0x3C=0xA5 then read it back
        xfer(M_WRITE, 8'h3C, 8'hA5, lat, rd);
        check("wr_lat", lat, 3);
        xfer(M_READ, 8'h3C, 8'h00, lat, rd);
        check("rd_lat", lat, 3);
        check("rd_data", rd, 8'hA5);

        // Preload wrap region and the abort target
        xfer(M_WRITE, 8'hFE, 8'h11, lat, rd);
        check("pre_fe_lat", lat, 3);
        xfer(M_WRITE, 8'hFF, 8'h22, lat, rd);
        xfer(M_WRITE, 8'h00, 8'h33, lat, rd);
        xfer(M_WRITE, 8'h01, 8'h44, lat, rd);
        xfer(M_WRITE, 8'h10, 8'h00, lat, rd);

        // Burst read from 0xFE wraps through 0xFF to 0x00, 0x01
        mode = M_BURST; addr = 8'hFE; start = 1'b1;
        tick();
        start = 1'b0;
        nr = 0;
        for (int k = 1; k <= 16; k++) begin
            if (rdy) begin
                if (nr < 4) begin
                    bt[nr] = k;
                    bd[nr] = rdata;
                end
                nr++;
            end
            tick();
        end
        check("burst_beats", nr, 4);
        check("burst_t0", bt[0], 3);
        check("burst_t1", bt[1], 6);
        check("burst_t2", bt[2], 9);
        check("burst_t3", bt[3], 12);
        check("burst_d0", bd[0], 8'h11);
        check("burst_d1", bd[1], 8'h22);
        check("burst_d2", bd[2], 8'h33);
        check("burst_d3", bd[3], 8'h44);

        // Abort: write 0x10=0x77, drop req one cycle after start
        mode = M_WRITE; addr = 8'h10; wdata = 8'h77; start = 1'b1;
        tick();
        start = 1'b0;
        req   = 1'b0;
        tick();
        check("abort_gnt", gnt, 0);
        nr = 0;
        for (int k = 0; k < 6; k++) begin
            if (rdy) nr++;
            tick();
        end
        check("abort_rdy", nr, 0);
        req = 1'b1;
        tick();
        xfer(M_READ, 8'h10, 8'h00, lat, rd);
        check("abort_rd", rd, 8'h00);

        // Busy start: a write to 0x3C during ACCESS must be ignored
        mode = M_READ; addr = 8'h3C; start = 1'b1;
        tick();
        mode = M_WRITE; addr = 8'h3C; wdata = 8'h99; start = 1'b1;
        tick();
        start = 1'b0;
        nr = 0; rc = 0; ne = 0; ec = 0; rd = '0;
        for (int k = 2; k <= 11; k++) begin
            if (rdy) begin
                nr++;
                rc = k;
                rd = rdata;
            end
`ifdef SB_MEM_PROT_ERR_EN
            if (err) begin
                ne++;
                ec = k;
            end
`endif
            tick();
        end
        check("busy_rdy_cnt", nr, 1);
        check("busy_rdy_t", rc, 3);
        check("busy_rdata", rd, 8'hA5);
`ifdef SB_MEM_PROT_ERR_EN
        check("busy_err_cnt", ne, 1);
        check("busy_err_t", ec, 2);
`endif
        xfer(M_READ, 8'h3C, 8'h00, lat, rd);
        check("busy_mem", rd, 8'hA5);

        // Nop transfer
        mode = M_NOP; addr = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        nr = 0; rc = 0; ne = 0; ec = 0;
        for (int k = 1; k <= 6; k++) begin
            if (rdy) begin
                nr++;
                rc = k;
            end
`ifdef SB_MEM_PROT_ERR_EN
            if (err) begin
                ne++;
                ec = k;
            end
`endif
            tick();
        end
`ifdef SB_MEM_PROT_ERR_EN
        check("nop_rdy_cnt", nr, 0);
        check("nop_err_cnt", ne, 1);
        check("nop_err_t", ec, 3);
`else
        check("nop_rdy_cnt", nr, 1);
        check("nop_rdy_t", rc, 3);
`endif

        // WAIT_CYCLES=0 instance: back-to-back reads
        req0 = 1'b1;
        tick();
        xfer0(M_WRITE, 8'h00, 8'h5A, lat, rd);
        check("w0_wr_lat", lat, 1);
        xfer0(M_WRITE, 8'h01, 8'hC3, lat, rd);
        mode0 = M_READ; addr0 = 8'h00; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("w0_rdy_a", rdy0, 1);
        check("w0_data_a", rdata0, 8'h5A);
        tick();
        check("w0_gap", rdy0, 0);
        addr0 = 8'h01; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("w0_rdy_b", rdy0, 1);
        check("w0_data_b", rdata0, 8'hC3);
        tick();

        // Asynchronous reset in the middle of a burst beat
        mode = M_BURST; addr = 8'hFE; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10 && !rdy; k++) tick();
        check("mid_rdy", rdy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_rdy", rdy, 0);
        check("mid_rst_rdata", rdata, 0);
        req  = 1'b0;
        req0 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_gnt", gnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
